// File: rtl/ar_rx_buf_pkg.sv
// ar_rx_buf_pkg: ARINC 429 word geometry shared by the receive buffer and its FIFO.
package ar_rx_buf_pkg;
    localparam int LBL_W  = 8;
    localparam int DAT_W  = 23;
    localparam int MAX_CH = 4;
    localparam int CH_W   = $clog2(MAX_CH);
    localparam int WORD_W = CH_W + LBL_W + DAT_W;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [LBL_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } word_t;

    function automatic logic lbl_ok(input logic en, input logic [LBL_W-1:0] flt, input logic [LBL_W-1:0] adr);
        return !en || adr == flt;
    endfunction
endpackage

// File: rtl/ar_fifo.sv
// ar_fifo: show-ahead synchronous FIFO; the head word is visible whenever not empty.
module ar_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [W-1:0]             wdat,
    input  logic                     rd,
    output logic [W-1:0]             rdat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          push, pop;

    always_comb begin
        empty = count == '0;
        full  = count == (AW+1)'(DEPTH);
        push  = wr && !full;
        pop   = rd && !empty;
        rdat  = empty ? '0 : mem[rp];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdat;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/ar_rx_buf.sv
// ar_rx_buf: per-channel pending registers with label filter, round-robin merge
// into a shared FIFO, and a saturating count of words dropped on busy channels.
module ar_rx_buf
    import ar_rx_buf_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         ce_wr,
    input  logic [8*NCH-1:0]       sr_adr,
    input  logic [23*NCH-1:0]      sr_dat,
    input  logic                   flt_en,
    input  logic [7:0]             lbl_flt,
    input  logic                   rd,
    output logic [7:0]             rd_adr,
    output logic [22:0]            rd_dat,
    output logic [1:0]             rd_ch,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   clr_ovf,
    output logic [7:0]             ovf_cnt
);
    logic [NCH-1:0]   pv, ok, gk, drop;
    logic [LBL_W-1:0] pa [NCH];
    logic [DAT_W-1:0] pd [NCH];
    logic [CH_W-1:0]  last, gnt_ch;
    logic             gnt_v;
    logic [CH_W:0]    ndrop;
    logic [8:0]       osum;
    word_t            wdat, head;

    // Grant priority starts at the channel after the last one granted.
    always_comb begin
        gnt_v = 1'b0;
        gnt_ch = '0;
        gk = '0;
        ok = '0;
        drop = '0;
        ndrop = '0;
        wdat = '0;
        for (int d = 1; d <= NCH; d++)
            for (int k = 0; k < NCH; k++)
                if (!gnt_v && !full && pv[k] && k == (int'(last) + d) % NCH) begin
                    gnt_v = 1'b1;
                    gnt_ch = CH_W'(k);
                end
        for (int k = 0; k < NCH; k++) begin
            ok[k] = lbl_ok(flt_en, lbl_flt, sr_adr[8*k +: 8]);
            gk[k] = gnt_v && gnt_ch == CH_W'(k);
            drop[k] = ce_wr[k] && ok[k] && pv[k] && !gk[k];
            ndrop = ndrop + (CH_W+1)'(drop[k]);
            if (gk[k]) wdat = {CH_W'(k), pa[k], pd[k]};
        end
        osum = {1'b0, ovf_cnt} + 9'(ndrop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pv      <= '0;
            last    <= CH_W'(NCH - 1);
            ovf_cnt <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (ce_wr[k] && ok[k] && (!pv[k] || gk[k])) begin
                    pv[k] <= 1'b1;
                    pa[k] <= sr_adr[8*k +: 8];
                    pd[k] <= sr_dat[23*k +: 23];
                end else if (gk[k]) begin
                    pv[k] <= 1'b0;
                end
            end
            if (gnt_v) last <= gnt_ch;
            ovf_cnt <= clr_ovf ? 8'h00 : osum[8] ? 8'hFF : osum[7:0];
        end
    end

    ar_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (gnt_v),
        .wdat  (wdat),
        .rd    (rd),
        .rdat  (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign rd_ch  = head.ch;
    assign rd_adr = head.adr;
    assign rd_dat = head.dat;
endmodule

// File: tb/tb_ar_rx_buf.sv
// tb_ar_rx_buf: directed scenarios plus random traffic, checked by a queue-based
// reference model and a monitor that compares every cycle.
module tb_ar_rx_buf;
    localparam int NCH   = 2;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ce_wr;
    logic [8*NCH-1:0]  sr_adr;
    logic [23*NCH-1:0] sr_dat;
    logic              flt_en;
    logic [7:0]        lbl_flt;
    logic              rd;
    logic [7:0]        rd_adr;
    logic [22:0]       rd_dat;
    logic [1:0]        rd_ch;
    logic              empty, full;
    logic [4:0]        count;
    logic              clr_ovf;
    logic [7:0]        ovf_cnt;

    ar_rx_buf #(.NCH(NCH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ce_wr(ce_wr), .sr_adr(sr_adr), .sr_dat(sr_dat),
        .flt_en(flt_en), .lbl_flt(lbl_flt), .rd(rd), .rd_adr(rd_adr), .rd_dat(rd_dat),
        .rd_ch(rd_ch), .empty(empty), .full(full), .count(count),
        .clr_ovf(clr_ovf), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending words per channel, words in the FIFO as a queue.
    bit          mpv [NCH];
    logic [7:0]  mpa [NCH];
    logic [22:0] mpd [NCH];
    int          mlast = NCH - 1;
    int          mcnt = 0;
    int          movf = 0;
    logic [32:0] exp_q [$];

    task automatic model_step();
        int g, drops;
        if (rst) begin
            foreach (mpv[i]) mpv[i] = 1'b0;
            mlast = NCH - 1;
            mcnt = 0;
            movf = 0;
            exp_q.delete();
            return;
        end
        g = -1;
        if (mcnt < DEPTH)
            for (int d = 1; d <= NCH && g < 0; d++)
                if (mpv[(mlast + d) % NCH]) g = (mlast + d) % NCH;
        if (rd && mcnt > 0) mcnt--;
        if (g >= 0) begin
            exp_q.push_back({2'(g), mpa[g], mpd[g]});
            mpv[g] = 1'b0;
            mlast = g;
            mcnt++;
        end
        drops = 0;
        for (int k = 0; k < NCH; k++)
            if (ce_wr[k] && (!flt_en || sr_adr[8*k +: 8] == lbl_flt)) begin
                if (mpv[k]) drops++;
                else begin
                    mpv[k] = 1'b1;
                    mpa[k] = sr_adr[8*k +: 8];
                    mpd[k] = sr_dat[23*k +: 23];
                end
            end
        movf = clr_ovf ? 0 : (movf + drops > 255 ? 255 : movf + drops);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: status every cycle, head word against the queue, pop on read.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("count", count, mcnt);
            chk("empty", empty, mcnt == 0);
            chk("full", full, mcnt == DEPTH);
            chk("ovf_cnt", ovf_cnt, movf);
            if (mcnt > 0 && exp_q.size() > 0) begin
                chk("head", {rd_ch, rd_adr, rd_dat}, exp_q[0]);
                if (rd) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce_wr = '0;
        rd = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic send(input int ch, input logic [7:0] a, input logic [22:0] d);
        ce_wr[ch] = 1'b1;
        sr_adr[8*ch +: 8] = a;
        sr_dat[23*ch +: 23] = d;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ce_wr = '0;
        sr_adr = '0;
        sr_dat = '0;
        flt_en = 1'b0;
        lbl_flt = '0;
        rd = 1'b0;
        clr_ovf = 1'b0;
        repeat (3) step();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf_cnt, 0);
        chk("rst_rd", {rd_ch, rd_adr, rd_dat}, 0);
        rst = 1'b0;

        // single word, two-edge latency
        send(0, 8'h2A, 23'h12345);
        step();
        idle();
        step();
        chk("single_empty", empty, 0);
        chk("single_adr", rd_adr, 8'h2A);
        chk("single_dat", rd_dat, 23'h12345);
        chk("single_ch", rd_ch, 0);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("single_pop", empty, 1);

        // contention from a fresh arbiter, then after a ch0-only grant
        do_reset();
        send(0, 8'hA0, 23'h1);
        send(1, 8'hA1, 23'h2);
        step();
        idle();
        repeat (2) step();
        chk("rr1_count", count, 2);
        chk("rr1_first", rd_ch, 0);
        rd = 1'b1;
        step();
        chk("rr1_second", rd_ch, 1);
        step();
        rd = 1'b0;
        send(0, 8'hB0, 23'h3);
        step();
        idle();
        step();
        rd = 1'b1;
        step();
        rd = 1'b0;
        send(0, 8'hC0, 23'h4);
        send(1, 8'hC1, 23'h5);
        step();
        idle();
        repeat (2) step();
        chk("rr2_first", rd_ch, 1);
        rd = 1'b1;
        step();
        chk("rr2_second", rd_ch, 0);
        step();
        rd = 1'b0;

        // label filter
        do_reset();
        flt_en = 1'b1;
        lbl_flt = 8'h31;
        send(0, 8'h30, 23'h30);
        step();
        send(0, 8'h31, 23'h31);
        step();
        send(0, 8'h32, 23'h32);
        step();
        idle();
        repeat (2) step();
        chk("flt_count", count, 1);
        chk("flt_adr", rd_adr, 8'h31);
        chk("flt_ovf", ovf_cnt, 0);
        flt_en = 1'b0;

        // overflow: 18 words, no reads
        do_reset();
        for (int i = 1; i <= 18; i++) begin
            send(0, 8'(i), 23'(i));
            step();
        end
        idle();
        step();
        chk("ovf_count", count, 16);
        chk("ovf_full", full, 1);
        chk("ovf_one", ovf_cnt, 1);
        rd = 1'b1;
        step();
        rd = 1'b0;
        step();
        chk("ovf_refill", count, 16);

        // saturation and clear
        send(0, 8'h55, 23'h55);
        step();
        repeat (300) begin
            send(0, 8'h56, 23'h56);
            step();
        end
        chk("sat_ovf", ovf_cnt, 255);
        send(0, 8'h57, 23'h57);
        clr_ovf = 1'b1;
        step();
        idle();
        chk("clr_ovf", ovf_cnt, 0);

        // reset mid-stream with a pending word on ch1
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(0, 8'h60 + 8'(i), 23'(i));
            step();
        end
        idle();
        step();
        chk("mid_count5", count, 5);
        send(1, 8'h77, 23'h77);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_empty", empty, 1);
        chk("mid_count0", count, 0);
        repeat (4) step();
        chk("mid_no_emit", empty, 1);

        // random traffic in segments with varied read pressure
        for (int s = 0; s < 12; s++) begin
            int prd = (s % 3 == 0) ? 10 : (s % 3 == 1) ? 50 : 90;
            flt_en = (s % 4 == 3);
            lbl_flt = 8'h30 + 8'($urandom_range(2));
            for (int c = 0; c < 250; c++) begin
                for (int k = 0; k < NCH; k++) begin
                    ce_wr[k] = $urandom_range(99) < 40;
                    sr_adr[8*k +: 8] = 8'h30 + 8'($urandom_range(2));
                    sr_dat[23*k +: 23] = 23'($urandom);
                end
                rd = $urandom_range(99) < prd;
                clr_ovf = $urandom_range(99) < 2;
                rst = $urandom_range(999) < 3;
                step();
            end
        end
        idle();
        rst = 1'b0;
        rd = 1'b1;
        repeat (24) step();
        chk("final_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ar_rx_buf.md
AR_RX_BUF -- requirements
Module: ar_rx_buf

Interface
REQ-001 Parameter NCH, 2, number of ARINC 429 receive channels (1..4).
REQ-002 Parameter DEPTH, 16, FIFO word depth (power of 2, 4..64).
REQ-003 Port clk  in  1  system clock (50 MHz via BUFG); all logic on rising edge.
REQ-004 Port rst  in  1  synchronous active-high reset.
REQ-005 Port ce_wr  in  NCH  per-channel one-cycle "word received correctly" strobe from AR_RXD.
REQ-006 Port sr_adr  in  8*NCH  per-channel received label; channel k at bits [8k+7:8k].
REQ-007 Port sr_dat  in  23*NCH  per-channel received data; channel k at bits [23k+22:23k].
REQ-008 Port flt_en  in  1  label filter enable.
REQ-009 Port lbl_flt  in  8  accepted label when flt_en=1.
REQ-010 Port rd  in  1  pop strobe for the head word.
REQ-011 Port rd_adr  out  8  head word label.
REQ-012 Port rd_dat  out  23  head word data.
REQ-013 Port rd_ch  out  2  head word source channel.
REQ-014 Port empty  out  1  FIFO holds no words.
REQ-015 Port full  out  1  FIFO holds DEPTH words.
REQ-016 Port count  out  log2(DEPTH)+1  words held.
REQ-017 Port clr_ovf  in  1  clear ovf_cnt.
REQ-018 Port ovf_cnt  out  8  dropped-word counter, saturating at 255.

Function
REQ-019 Each channel SHALL own a pending register (valid, label, data); ce_wr[k]=1 loads it at the next edge if the channel is free and the word passes the filter.
REQ-020 With flt_en=1, a word whose label differs from lbl_flt SHALL be discarded silently (not counted).
REQ-021 A ce_wr[k] while pending[k] is valid and not granted that cycle SHALL drop the new word, keep the old one and increment ovf_cnt.
REQ-022 A ce_wr[k] on the same cycle pending[k] is granted SHALL load the new word (no drop).
REQ-023 A round-robin arbiter SHALL grant at most one valid pending channel per cycle, searching upward from the channel after the last granted one, wrapping at NCH-1.
REQ-024 A grant SHALL occur only when full=0 (registered value); the granted word is written into the FIFO and its pending valid cleared at the same edge.
REQ-025 The FIFO SHALL be show-ahead: rd_adr/rd_dat/rd_ch present the head word whenever empty=0.
REQ-026 rd=1 with empty=0 SHALL pop the head at the next edge; rd with empty=1 SHALL be ignored.
REQ-027 Simultaneous write and pop SHALL leave count unchanged; read and write pointers wrap modulo DEPTH.
REQ-028 Latency: ce_wr at edge n with FIFO empty and no contention -> word on rd_* with empty=0 after edge n+2.
REQ-029 ovf_cnt SHALL saturate at 255; clr_ovf=1 SHALL zero it, with clear taking priority over a same-cycle increment.
REQ-030 When full=1, pending words SHALL wait; no FIFO entry is ever overwritten.

Reset
REQ-031 rst=1 SHALL clear all pending valids, FIFO pointers, count, ovf_cnt and the arbiter pointer (last granted = NCH-1, so channel 0 wins first).
REQ-032 After reset: empty=1, full=0, count=0, ovf_cnt=0, rd_* = 0.
REQ-033 rst mid-operation SHALL discard all buffered and pending words; ce_wr during rst is ignored.

Structure
REQ-034 A shared package SHALL hold ARINC constants: label width 8, data width 23, maximum channel count 4.
REQ-035 The FIFO SHALL be a separate sub-module ar_fifo (parameters DEPTH, width 33), instantiated once.

Verification
REQ-036 Single word: ch0 ce_wr, adr=8'h2A, dat=23'h12345 -> after 2 edges empty=0, rd_adr=2A, rd_dat=12345, rd_ch=0; rd -> empty=1.
REQ-037 Contention: ce_wr on ch0 and ch1 in the same cycle -> FIFO order ch0 then ch1; repeat -> ch1 then ch0 (round-robin).
REQ-038 Filter: flt_en=1, lbl_flt=8'h31; words with labels 30, 31, 32 -> only label 31 stored, ovf_cnt=0.
REQ-039 Overflow: DEPTH=16, no reads, 18 words on ch0 -> count=16, full=1, pending holds word 17, word 18 dropped, ovf_cnt=1; one rd -> word 17 enters, count=16.
REQ-040 Saturation and clear: 300 forced drops -> ovf_cnt=255; clr_ovf together with a drop -> ovf_cnt=0.
REQ-041 Reset mid-stream: rst with count=5 and ch1 pending -> next cycle empty=1, count=0, no later emission of the pending word.
